hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: one clock `clk`; reset `reset`.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have ports `rs_addr_D` and `rt_addr_D`, inputs, 5 bits each: source register numbers of the instruction in D.
REQ-005 SHALL have ports `rs_use_D` and `rt_use_D`, inputs, 4 bits each: cycles until that operand is needed; value 4 means "unused".
REQ-006 SHALL have ports `dst_addr_E` and `dst_addr_M`, inputs, 5 bits each: destination register of the instruction in E / M.
REQ-007 SHALL have ports `dst_save_E` and `dst_save_M`, inputs, 4 bits each: remaining cycles until that result is forwardable.
REQ-008 SHALL have ports `md_start_E` (input, 1 bit: a mult/div issues in E this cycle) and `md_type_E` (input, 1 bit: 0 = mult, 1 = div).
REQ-009 SHALL have ports `md_use_D` (input, 1 bit: D instruction touches HI/LO or the md unit) and `exc_req` (input, 1 bit: exception/interrupt taken in M).
REQ-010 SHALL have outputs `pc_en`, `d_en`, `e_flush` and `flush_all`, 1 bit each: PC enable, F/D pipeline-register enable, E bubble insert, flush of D/E/M.
REQ-011 SHALL have outputs `stall` (1 bit), `md_busy` (1 bit) and `stall_cnt` (32 bits: saturating count of stall cycles).

Function
REQ-012 SHALL assert `hz_rs` when `rs_addr_D`≠0 and (`rs_addr_D`==`dst_addr_E` and `dst_save_E`>`rs_use_D`, or `rs_addr_D`==`dst_addr_M` and `dst_save_M`>`rs_use_D`); `hz_rt` is defined the same way for rt.
REQ-013 SHALL hold a 4-bit md counter that loads 5 on `md_start_E` with `md_type_E`=0 and 10 with `md_type_E`=1, and otherwise decrements each cycle while nonzero.
REQ-014 SHALL reload the md counter from `md_type_E` when `md_start_E` arrives while the counter is nonzero, discarding the old value.
REQ-015 SHALL drive `md_busy` = (counter≠0) OR `md_start_E`, combinationally.
REQ-016 SHALL drive `stall` = (`hz_rs` OR `hz_rt` OR (`md_use_D` AND `md_busy`)) AND NOT `exc_req`.
REQ-017 SHALL drive, when `stall`=1: `pc_en`=0, `d_en`=0, `e_flush`=1, `flush_all`=0.
REQ-018 SHALL drive, when `exc_req`=1: `flush_all`=1, `pc_en`=1, `d_en`=1, `e_flush`=0, with exception priority over any stall.
REQ-019 SHALL drive, otherwise: `pc_en`=1, `d_en`=1, `e_flush`=0, `flush_all`=0.
REQ-020 SHALL let the md counter keep counting through `exc_req`, because an issued mult/div is not cancelled.
REQ-021 SHALL increment `stall_cnt` by 1 on every clock edge with `stall`=1, saturating at 0xFFFFFFFF without wrapping.
REQ-022 SHALL produce all control outputs combinationally from the current inputs and state (zero-cycle latency); only the md counter and `stall_cnt` are registered.

Reset
REQ-023 SHALL, on a clock edge with `reset`=1, clear the md counter and `stall_cnt` to 0, overriding `md_start_E` and `stall` on that edge.
REQ-024 SHALL, while `reset`=1, force `stall`=0, `md_busy`=0, `pc_en`=1, `d_en`=1, `e_flush`=0 and `flush_all`=0.
REQ-025 SHALL, when reset is asserted mid-division, abandon the remaining count; `md_busy`=0 from the first cycle after reset.

Structure
REQ-026 SHALL take constants `MULT_CYCLES`=5, `DIV_CYCLES`=10 and `USE_NONE`=4 from the shared pipeline package.
REQ-027 SHALL implement the per-operand compare of REQ-012 as sub-module `hazard_cmp`, instantiated once for rs and once for rt.

Verification
REQ-028 SHALL check: `rs_addr_D`=5, `rs_use_D`=0, `dst_addr_E`=5, `dst_save_E`=2 -> `stall`=1, `pc_en`=0, `e_flush`=1; with `dst_save_E`=0 -> `stall`=0.
REQ-029 SHALL check: `rt_addr_D`=0 matching `dst_addr_M`=0 with `dst_save_M`=3 -> `stall`=0; and `rs_use_D`=4 with any address match -> `stall`=0.
REQ-030 SHALL check: `md_start_E` with `md_type_E`=1, then `md_use_D`=1 -> `stall`=1 for exactly 10 cycles after the start edge, 0 on the 11th; `stall_cnt`=10.
REQ-031 SHALL check: `exc_req`=1 while `hz_rs`=1 -> `flush_all`=1, `stall`=0, `pc_en`=1; the md counter is unaffected.
REQ-032 SHALL check: `reset` asserted at md counter=7 -> counter 0, `md_busy`=0 and `stall_cnt`=0 on the next cycle.
REQ-033 SHALL check: `stall_cnt` preloaded to 0xFFFFFFFE with `stall` held for 3 cycles -> `stall_cnt` reads 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants and types for the hazard controller.
package hazard_ctrl_pkg;
    localparam int REG_W     = 5;
    localparam int CYC_W     = 4;
    localparam int MD_CNT_W  = 4;
    localparam int STALL_CNT_W = 32;

    localparam logic [CYC_W-1:0]    USE_NONE    = 4'd4;
    localparam logic [MD_CNT_W-1:0] MULT_CYCLES = 4'd5;
    localparam logic [MD_CNT_W-1:0] DIV_CYCLES  = 4'd10;

    typedef enum logic {MD_MULT = 1'b0, MD_DIV = 1'b1} md_type_e;

    function automatic logic [MD_CNT_W-1:0] md_latency(input md_type_e md_type);
        return (md_type == MD_DIV) ? DIV_CYCLES : MULT_CYCLES;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the D/E/M stages and the hazard controller.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_W-1:0]       rs_addr_D;
    logic [REG_W-1:0]       rt_addr_D;
    logic [CYC_W-1:0]       rs_use_D;
    logic [CYC_W-1:0]       rt_use_D;
    logic [REG_W-1:0]       dst_addr_E;
    logic [REG_W-1:0]       dst_addr_M;
    logic [CYC_W-1:0]       dst_save_E;
    logic [CYC_W-1:0]       dst_save_M;
    logic                   md_start_E;
    logic                   md_type_E;
    logic                   md_use_D;
    logic                   exc_req;
    logic                   pc_en;
    logic                   d_en;
    logic                   e_flush;
    logic                   flush_all;
    logic                   stall;
    logic                   md_busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output rs_addr_D, rt_addr_D, rs_use_D, rt_use_D,
               dst_addr_E, dst_addr_M, dst_save_E, dst_save_M,
               md_start_E, md_type_E, md_use_D, exc_req,
        input  pc_en, d_en, e_flush, flush_all, stall, md_busy, stall_cnt
    );

    modport slave (
        input  rs_addr_D, rt_addr_D, rs_use_D, rt_use_D,
               dst_addr_E, dst_addr_M, dst_save_E, dst_save_M,
               md_start_E, md_type_E, md_use_D, exc_req,
        output pc_en, d_en, e_flush, flush_all, stall, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Per-operand RAW check: operand is needed before an in-flight producer can forward it.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_addr,
    input  logic [CYC_W-1:0] src_use,
    input  logic [REG_W-1:0] dst_addr_e,
    input  logic [CYC_W-1:0] dst_save_e,
    input  logic [REG_W-1:0] dst_addr_m,
    input  logic [CYC_W-1:0] dst_save_m,
    output logic             hz
);
    logic hit_e, hit_m;

    // $zero never carries a dependency, regardless of what E/M claim to write
    assign hit_e = (src_addr == dst_addr_e) && (dst_save_e > src_use);
    assign hit_m = (src_addr == dst_addr_m) && (dst_save_m > src_use);
    assign hz    = (src_addr != '0) && (hit_e || hit_m);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: register RAW hazards, mult/div occupancy, exception flush.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    logic [MD_CNT_W-1:0]    md_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   hz_rs, hz_rt;
    logic                   md_busy_w, stall_w, flush_w;

    hazard_cmp u_cmp_rs (
        .src_addr   (bus.rs_addr_D),
        .src_use    (bus.rs_use_D),
        .dst_addr_e (bus.dst_addr_E),
        .dst_save_e (bus.dst_save_E),
        .dst_addr_m (bus.dst_addr_M),
        .dst_save_m (bus.dst_save_M),
        .hz         (hz_rs)
    );

    hazard_cmp u_cmp_rt (
        .src_addr   (bus.rt_addr_D),
        .src_use    (bus.rt_use_D),
        .dst_addr_e (bus.dst_addr_E),
        .dst_save_e (bus.dst_save_E),
        .dst_addr_m (bus.dst_addr_M),
        .dst_save_m (bus.dst_save_M),
        .hz         (hz_rt)
    );

    // Exception wins over every stall source; reset masks everything
    always_comb begin
        md_busy_w = ~reset & ((md_cnt_q != '0) | bus.md_start_E);
        stall_w   = ~reset & ~bus.exc_req & (hz_rs | hz_rt | (bus.md_use_D & md_busy_w));
        flush_w   = ~reset & bus.exc_req;
    end

    assign bus.stall     = stall_w;
    assign bus.md_busy   = md_busy_w;
    assign bus.pc_en     = ~stall_w;
    assign bus.d_en      = ~stall_w;
    assign bus.e_flush   = stall_w;
    assign bus.flush_all = flush_w;
    assign bus.stall_cnt = stall_cnt_q;

    // An issued mult/div keeps counting through exceptions; a new start reloads
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.md_start_E)
                md_cnt_q <= md_latency(md_type_e'(bus.md_type_E));
            else if (md_cnt_q != '0)
                md_cnt_q <= md_cnt_q - 1'b1;

            if (stall_w && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl_if hif ();
    hazard_ctrl dut (.clk(clk), .reset(reset), .bus(hif));

    always #5 clk = ~clk;

    // {stall, md_busy, pc_en, d_en, e_flush, flush_all}
    localparam logic [5:0] IDLE     = 6'b001100;
    localparam logic [5:0] STALL    = 6'b100010;
    localparam logic [5:0] MDSTALL  = 6'b110010;
    localparam logic [5:0] BUSY     = 6'b011100;
    localparam logic [5:0] EXC_BUSY = 6'b011101;

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        bit          cnt_v;
        logic [31:0] cnt;
        bit          mdc_v;
        logic [3:0]  mdc;
    } exp_t;

    exp_t sb[$];

    task automatic cyc(input string tag, input logic [5:0] ctl,
                       input bit cnt_v, input logic [31:0] cnt,
                       input bit mdc_v, input logic [3:0] mdc);
        exp_t e;
        logic [5:0] obs;
        e.tag = tag; e.ctl = ctl; e.cnt_v = cnt_v; e.cnt = cnt; e.mdc_v = mdc_v; e.mdc = mdc;
        sb.push_back(e);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = {hif.stall, hif.md_busy, hif.pc_en, hif.d_en, hif.e_flush, hif.flush_all};
            checks++;
            assert (obs === e.ctl) else begin
                failures++;
                $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
            end
            if (e.cnt_v) begin
                checks++;
                assert (hif.stall_cnt === e.cnt) else begin
                    failures++;
                    $error("FAIL %s stall_cnt observed=%h expected=%h", e.tag, hif.stall_cnt, e.cnt);
                end
            end
            if (e.mdc_v) begin
                checks++;
                assert (dut.md_cnt_q === e.mdc) else begin
                    failures++;
                    $error("FAIL %s md_cnt observed=%0d expected=%0d", e.tag, dut.md_cnt_q, e.mdc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        hif.rs_addr_D = '0; hif.rt_addr_D = '0;
        hif.rs_use_D = 4'd4; hif.rt_use_D = 4'd4;
        hif.dst_addr_E = '0; hif.dst_addr_M = '0;
        hif.dst_save_E = '0; hif.dst_save_M = '0;
    endtask

    initial begin
        clear_ops();
        hif.md_start_E = 1'b0; hif.md_type_E = 1'b0;
        hif.md_use_D = 1'b0; hif.exc_req = 1'b0;

        // reset masks a live hazard and an md start
        reset = 1'b1;
        hif.rs_addr_D = 5'd5; hif.rs_use_D = 4'd0; hif.dst_addr_E = 5'd5; hif.dst_save_E = 4'd2;
        hif.md_start_E = 1'b1; hif.md_use_D = 1'b1;
        cyc("reset_state", IDLE, 1, 32'd0, 1, 4'd0);

        reset = 1'b0; hif.md_start_E = 1'b0; hif.md_use_D = 1'b0;
        cyc("rs_hz_E", STALL, 1, 32'd0, 0, '0);
        hif.dst_save_E = 4'd0;
        cyc("rs_save0", IDLE, 1, 32'd1, 0, '0);

        clear_ops();
        hif.rt_addr_D = 5'd7; hif.rt_use_D = 4'd1; hif.dst_addr_M = 5'd7; hif.dst_save_M = 4'd3;
        cyc("rt_hz_M", STALL, 1, 32'd1, 0, '0);
        hif.rt_addr_D = 5'd0; hif.rt_use_D = 4'd0; hif.dst_addr_M = 5'd0;
        cyc("rt_zero_reg", IDLE, 1, 32'd2, 0, '0);

        clear_ops();
        hif.rs_addr_D = 5'd5; hif.rs_use_D = 4'd4;
        hif.dst_addr_E = 5'd5; hif.dst_save_E = 4'd3; hif.dst_addr_M = 5'd5; hif.dst_save_M = 4'd3;
        cyc("rs_unused", IDLE, 0, '0, 0, '0);
        hif.rs_use_D = 4'd1; hif.dst_save_E = 4'd1; hif.dst_save_M = 4'd0;
        cyc("save_eq_use", IDLE, 0, '0, 0, '0);

        clear_ops();
        reset = 1'b1; hif.md_start_E = 1'b1;
        cyc("reset_pre_div", IDLE, 1, 32'd2, 0, '0);

        // div: md_use only after the start edge gives exactly 10 stalls
        reset = 1'b0; hif.md_start_E = 1'b1; hif.md_type_E = 1'b1;
        cyc("div_start", BUSY, 1, 32'd0, 1, 4'd0);
        hif.md_start_E = 1'b0; hif.md_use_D = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc($sformatf("div_stall%0d", i), MDSTALL, 1, 32'(i), 1, 4'(10 - i));
        cyc("div_done", IDLE, 1, 32'd10, 1, 4'd0);

        // exception during a hazard with a mult in flight
        hif.md_use_D = 1'b0; hif.md_start_E = 1'b1; hif.md_type_E = 1'b0;
        cyc("mult_start", BUSY, 0, '0, 1, 4'd0);
        hif.md_start_E = 1'b0; hif.md_use_D = 1'b1; hif.exc_req = 1'b1;
        hif.rs_addr_D = 5'd5; hif.rs_use_D = 4'd0; hif.dst_addr_E = 5'd5; hif.dst_save_E = 4'd2;
        cyc("exc_over_hz", EXC_BUSY, 1, 32'd10, 1, 4'd5);

        // reload while busy, then reset mid-division at count 7
        clear_ops();
        hif.exc_req = 1'b0; hif.md_use_D = 1'b0; hif.md_start_E = 1'b1; hif.md_type_E = 1'b1;
        cyc("reload", BUSY, 0, '0, 1, 4'd4);
        hif.md_start_E = 1'b0;
        cyc("reload_10", BUSY, 0, '0, 1, 4'd10);
        cyc("count_9", BUSY, 0, '0, 1, 4'd9);
        cyc("count_8", BUSY, 0, '0, 1, 4'd8);
        reset = 1'b1; hif.md_start_E = 1'b1; hif.md_use_D = 1'b1;
        hif.rs_addr_D = 5'd5; hif.rs_use_D = 4'd0; hif.dst_addr_E = 5'd5; hif.dst_save_E = 4'd2;
        cyc("reset_at7", IDLE, 1, 32'd10, 1, 4'd7);
        clear_ops();
        reset = 1'b0; hif.md_start_E = 1'b0;
        cyc("after_reset", IDLE, 1, 32'd0, 1, 4'd0);

        // saturation of the stall counter
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        @(posedge clk);
        #1;
        hif.md_use_D = 1'b0;
        hif.rs_addr_D = 5'd9; hif.rs_use_D = 4'd0; hif.dst_addr_M = 5'd9; hif.dst_save_M = 4'd1;
        cyc("sat0", STALL, 1, 32'hFFFF_FFFE, 0, '0);
        cyc("sat1", STALL, 1, 32'hFFFF_FFFF, 0, '0);
        cyc("sat2", STALL, 1, 32'hFFFF_FFFF, 0, '0);
        clear_ops();
        cyc("sat_hold", IDLE, 1, 32'hFFFF_FFFF, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
